// File: rtl/light_phase_scheduler.sv
// Four-way intersection phase sequencer: NS green / clear / EW green / clear,
// with optional protected-left phases compiled in by defining LEFT_PHASE_EN.
module light_phase_scheduler #(
  parameter int unsigned TW         = 8,
  parameter int unsigned MIN_GREEN  = 20,
  parameter int unsigned MAX_GREEN  = 100,
  parameter int unsigned CLEAR_TIME = 6,
  parameter int unsigned LEFT_TIME  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sensor_light,
  input  logic [29:0] general_sensors,
  output logic [2:0]  outN,
  output logic [2:0]  outS,
  output logic [2:0]  outE,
  output logic [2:0]  outW,
  output logic [29:0] debug_port
);

  localparam logic [2:0] STOP = 3'b000;
  localparam logic [2:0] GO   = 3'b100;
`ifdef LEFT_PHASE_EN
  localparam logic [2:0] LEFT = 3'b010;
  localparam logic [TW-1:0] LEFT_T = TW'(LEFT_TIME);
`endif
  localparam logic [TW-1:0] MIN_T = TW'(MIN_GREEN);
  localparam logic [TW-1:0] MAX_T = TW'(MAX_GREEN);
  localparam logic [TW-1:0] CLR_T = TW'(CLEAR_TIME);

  if (MIN_GREEN > MAX_GREEN || MAX_GREEN > (2**TW) - 1 ||
      CLEAR_TIME > (2**TW) - 1 || LEFT_TIME > (2**TW) - 1) begin : g_param_err
    $error("light_phase_scheduler: illegal timing parameters");
  end

  typedef enum logic [2:0] {
    NS_GO  = 3'd0,
    NS_CLR = 3'd1,
    EW_GO  = 3'd2,
    EW_CLR = 3'd3
`ifdef LEFT_PHASE_EN
    ,
    NS_LT  = 3'd4,
    EW_LT  = 3'd5
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    n_q, s_q, e_q, w_q;
  logic [2:0]    n_d, s_d, e_d, w_d;
  logic          ns_dem, ew_dem, box_busy;
  logic [7:0]    dbg_tim;
  logic          unused_general;

  assign ns_dem   = sensor_light[6] | sensor_light[4];
  assign ew_dem   = sensor_light[5] | sensor_light[7];
  assign box_busy = |sensor_light[3:0];
  assign unused_general = ^general_sensors;

  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_GO:
        if (timer_q >= MIN_T && ew_dem && (!ns_dem || timer_q >= MAX_T)) state_d = NS_CLR;
      EW_GO:
        if (timer_q >= MIN_T && ns_dem && (!ew_dem || timer_q >= MAX_T)) state_d = EW_CLR;
`ifdef LEFT_PHASE_EN
      NS_CLR: if (timer_q >= CLR_T && !box_busy) state_d = EW_LT;
      EW_CLR: if (timer_q >= CLR_T && !box_busy) state_d = NS_LT;
      NS_LT:  if (timer_q >= LEFT_T) state_d = NS_GO;
      EW_LT:  if (timer_q >= LEFT_T) state_d = EW_GO;
`else
      NS_CLR: if (timer_q >= CLR_T && !box_busy) state_d = EW_GO;
      EW_CLR: if (timer_q >= CLR_T && !box_busy) state_d = NS_GO;
`endif
      default: state_d = EW_CLR;
    endcase
  end

  // Saturating timer: a box that stays occupied must never wrap into an exit.
  always_comb begin
    if (state_d != state_q) timer_d = '0;
    else if (timer_q == '1) timer_d = timer_q;
    else                    timer_d = timer_q + TW'(1);
  end

  // Lights decode from the next state so they flip on the same edge as the state.
  always_comb begin
    n_d = STOP;
    s_d = STOP;
    e_d = STOP;
    w_d = STOP;
    case (state_d)
      NS_GO: begin n_d = GO; s_d = GO; end
      EW_GO: begin e_d = GO; w_d = GO; end
`ifdef LEFT_PHASE_EN
      NS_LT: begin n_d = LEFT; s_d = LEFT; end
      EW_LT: begin e_d = LEFT; w_d = LEFT; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EW_CLR;
      timer_q <= '0;
      n_q     <= STOP;
      s_q     <= STOP;
      e_q     <= STOP;
      w_q     <= STOP;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      n_q     <= n_d;
      s_q     <= s_d;
      e_q     <= e_d;
      w_q     <= w_d;
    end
  end

  if (TW >= 8) begin : g_tim_wide
    assign dbg_tim = timer_q[7:0];
  end else begin : g_tim_narrow
    assign dbg_tim = {{(8-TW){1'b0}}, timer_q};
  end

  assign outN = n_q;
  assign outS = s_q;
  assign outE = e_q;
  assign outW = w_q;
  assign debug_port = {11'd0, state_q, dbg_tim, sensor_light};

endmodule

// File: tb/tb_light_phase_scheduler.sv
// Scoreboard bench for light_phase_scheduler; a cycle model pushes expected
// state/timer/lights as stimulus is applied, popped after each edge.
module tb_light_phase_scheduler;

  localparam logic [2:0] STOP = 3'b000;
  localparam logic [2:0] GO   = 3'b100;
  localparam logic [2:0] LEFT = 3'b010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sl  = 8'h00;
  logic [29:0] gs  = '0;
  logic [2:0]  outN, outS, outE, outW;
  logic [29:0] dbg;

  always #5 clk = ~clk;

  light_phase_scheduler #(
    .TW(8), .MIN_GREEN(20), .MAX_GREEN(100), .CLEAR_TIME(6), .LEFT_TIME(10)
  ) dut (
    .clk(clk), .rst(rst), .sensor_light(sl), .general_sensors(gs),
    .outN(outN), .outS(outS), .outE(outE), .outW(outW), .debug_port(dbg)
  );

  typedef struct {
    int         st;
    int         tm;
    logic [11:0] lights;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   m_st  = 3;
  int   m_tm  = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] lights_of(input int st);
    case (st)
      0: return {GO, GO, STOP, STOP};
      2: return {STOP, STOP, GO, GO};
      4: return {LEFT, LEFT, STOP, STOP};
      5: return {STOP, STOP, LEFT, LEFT};
      default: return {STOP, STOP, STOP, STOP};
    endcase
  endfunction

  function automatic int nxt(input int st, input int t, input logic [7:0] s);
    logic ns, ew, box;
    ns  = s[6] | s[4];
    ew  = s[5] | s[7];
    box = |s[3:0];
    case (st)
      0: return (t >= 20 && ew && (!ns || t >= 100)) ? 1 : 0;
      2: return (t >= 20 && ns && (!ew || t >= 100)) ? 3 : 2;
`ifdef LEFT_PHASE_EN
      1: return (t >= 6 && !box) ? 5 : 1;
      3: return (t >= 6 && !box) ? 4 : 3;
      4: return (t >= 10) ? 0 : 4;
      5: return (t >= 10) ? 2 : 5;
`else
      1: return (t >= 6 && !box) ? 2 : 1;
      3: return (t >= 6 && !box) ? 0 : 3;
`endif
      default: return 3;
    endcase
  endfunction

  task automatic step(input logic r, input logic [7:0] s);
    exp_t e;
    e.st     = r ? 3 : nxt(m_st, m_tm, s);
    e.tm     = (r || e.st != m_st) ? 0 : ((m_tm >= 255) ? 255 : m_tm + 1);
    e.lights = lights_of(e.st);
    sb.push_back(e);
    rst = r;
    sl  = s;
    gs  = 30'($urandom);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_val("state",  32'(dbg[18:16]), 32'(e.st));
    check_val("timer",  32'(dbg[15:8]), 32'(e.tm));
    check_val("lights", 32'({outN, outS, outE, outW}), 32'(e.lights));
    check_val("dbg_sens", 32'(dbg[7:0]), 32'(s));
    check_val("dbg_zero", 32'(dbg[29:19]), 32'd0);
    m_st = e.st;
    m_tm = e.tm;
  endtask

  task automatic run_until(input int target, input logic [7:0] s, input int budget,
                           input string tag, output int n);
    n = 0;
    while (m_st != target && n < budget) begin
      step(1'b0, s);
      n++;
    end
    check_val(tag, 32'(dbg[18:16]), 32'(target));
  endtask

  initial begin
    int n;
    int after_clr;
`ifdef LEFT_PHASE_EN
    after_clr = 4;
`else
    after_clr = 0;
`endif

    repeat (3) step(1'b1, 8'h00);
    check_val("rst_lights", 32'({outN, outS, outE, outW}), 32'd0);

    run_until(after_clr, 8'h00, 20, "reach_first", n);
    check_val("rst_clear_edges", 32'(n - 1), 32'd6);
`ifdef LEFT_PHASE_EN
    run_until(0, 8'h00, 20, "ns_lt_to_go", n);
    check_val("ns_left_len", 32'(n), 32'd11);
`endif
    check_val("first_green_n", 32'(outN), 32'(GO));

    run_until(1, 8'h20, 40, "ns_yield_min", n);
    check_val("ns_min_hold", 32'(n), 32'd21);
`ifdef LEFT_PHASE_EN
    run_until(5, 8'h20, 20, "ns_clr_exit", n);
    run_until(2, 8'h20, 20, "ew_lt_to_go", n);
`else
    run_until(2, 8'h20, 20, "ns_clr_exit", n);
    check_val("ns_clear_len", 32'(n), 32'd7);
`endif

    repeat (30) step(1'b0, 8'h00);
    check_val("ew_hold_no_dem", 32'(dbg[18:16]), 32'd2);

    run_until(3, 8'h60, 120, "ew_yield_max", n);
    check_val("ew_max_hold", 32'(n), 32'd71);
    run_until(after_clr, 8'h60, 20, "ew_clr_exit", n);
`ifdef LEFT_PHASE_EN
    run_until(0, 8'h60, 20, "ns_lt_to_go2", n);
`endif

    run_until(1, 8'h60, 120, "ns_yield_max", n);
    check_val("ns_max_hold", 32'(n), 32'd101);

    repeat (50) step(1'b0, 8'h01);
    check_val("box_hold_state", 32'(dbg[18:16]), 32'd1);
    check_val("box_hold_lights", 32'({outN, outS, outE, outW}), 32'd0);
`ifdef LEFT_PHASE_EN
    run_until(5, 8'h00, 3, "box_release", n);
    check_val("box_release_len", 32'(n), 32'd1);
    run_until(2, 8'h00, 20, "ew_lt_to_go2", n);
`else
    run_until(2, 8'h00, 3, "box_release", n);
    check_val("box_release_len", 32'(n), 32'd1);
`endif

    repeat (30) step(1'b0, 8'h00);
    check_val("ew_timer_30", 32'(dbg[15:8]), 32'd30);
    step(1'b1, 8'h00);
    check_val("mid_rst_state", 32'(dbg[18:16]), 32'd3);
    check_val("mid_rst_timer", 32'(dbg[15:8]), 32'd0);

    repeat (300) step(1'b0, 8'h08);
    check_val("timer_saturate", 32'(dbg[15:8]), 32'd255);
    check_val("sat_still_clr", 32'(dbg[18:16]), 32'd3);
    run_until(after_clr, 8'h00, 3, "sat_release", n);
    check_val("sat_release_len", 32'(n), 32'd1);
`ifdef LEFT_PHASE_EN
    check_val("lt_lights", 32'({outN, outS, outE, outW}), 32'({LEFT, LEFT, STOP, STOP}));
    run_until(0, 8'h00, 20, "ns_lt_to_go3", n);
    check_val("ns_left_len2", 32'(n), 32'd11);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
